// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one spi_master among N requesters, with per-slave select decode.
// Define SPI_ARB_TIMEOUT_EN to abort a grant whose m_busy fails to rise within TIMEOUT_CYCLES.
module spi_arbiter #(
    parameter int N              = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] tx_data,
    input  logic [N-1:0]   cpol,
    input  logic [N-1:0]   cpha,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic           err,
    output logic [7:0]     rx_data,
    output logic [7:0]     m_data_in,
    output logic           m_cpol,
    output logic           m_cpha,
    output logic           m_start,
    input  logic           m_busy,
    input  logic [7:0]     m_data_out,
    input  logic           m_cs,
    output logic [N-1:0]   ss_n
);
    localparam int PW = $clog2(N);
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_END, DONE} state_t;
    state_t        state, state_nx;
    logic [PW-1:0] ptr, gidx, off, win, ptr_nx;
    logic [PW:0]   sum;
    logic [N-1:0]  rot;
    logic          timeout, finish;

    if (N < 2 || N > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("spi_arbiter: N must be 2..8 and TIMEOUT_CYCLES positive");
    end

    // Rotate requests so bit 0 sits at the pointer; the lowest set bit of rot wins.
    assign rot = N'({req, req} >> ptr);
    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) off = PW'(i);
    end
    assign sum    = {1'b0, ptr} + {1'b0, off};
    assign win    = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
    assign ptr_nx = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else        cnt <= (state == WAIT_BUSY) ? cnt + CW'(1) : '0;
    assign timeout = (state == WAIT_BUSY) && !m_busy && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = |req ? LOAD : IDLE;
            LOAD:      state_nx = START;
            START:     state_nx = WAIT_BUSY;
            WAIT_BUSY: state_nx = timeout ? IDLE : (m_busy ? WAIT_END : WAIT_BUSY);
            WAIT_END:  state_nx = m_busy ? WAIT_END : DONE;
            default:   state_nx = IDLE;
        endcase
    end

    assign finish  = (state == DONE) || timeout;
    assign done    = finish ? grant : '0;
    assign err     = timeout;
    assign m_start = (state == START);
    assign ss_n    = ~grant | {N{m_cs}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            gidx      <= '0;
            grant     <= '0;
            m_data_in <= '0;
            m_cpol    <= 1'b0;
            m_cpha    <= 1'b0;
            rx_data   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && |req) begin
                gidx      <= win;
                grant     <= N'(1) << win;
                m_data_in <= tx_data[{win, 3'b000} +: 8];
                m_cpol    <= cpol[win];
                m_cpha    <= cpha[win];
            end
            if (state == WAIT_END && !m_busy) rx_data <= m_data_out;
            if (finish) begin
                grant <= '0;
                ptr   <= ptr_nx;
            end
        end
    end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: randomized self-checking bench for spi_arbiter, using a round-robin reference model
// and a behavioural spi_master stub; the timeout scenario runs when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_arbiter;
    localparam int N  = 4;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, cpol, cpha, grant, done, ss_n;
    logic [8*N-1:0] tx_data, sbytes;
    logic           err, m_cpol, m_cpha, m_start, m_busy, m_cs;
    logic [7:0]     rx_data, m_data_in, m_data_out;

    int errors = 0, checks = 0, cyc = 0, ptr_m = 0;
    int scyc, ob_cyc, st, cnt, sg;
    logic [7:0]   cap_data;
    logic         cap_cpol, cap_cpha, ob_err;
    logic [N-1:0] cap_grant, ob_done, ob_ss;
    bit           hang = 1'b0;

    spi_arbiter #(.N(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .tx_data(tx_data), .cpol(cpol), .cpha(cpha),
        .grant(grant), .done(done), .err(err), .rx_data(rx_data), .m_data_in(m_data_in),
        .m_cpol(m_cpol), .m_cpha(m_cpha), .m_start(m_start), .m_busy(m_busy),
        .m_data_out(m_data_out), .m_cs(m_cs), .ss_n(ss_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // spi_master stand-in: random busy-rise delay and transfer length; returns the granted slave's byte
    initial begin
        m_busy = 1'b0; m_cs = 1'b1; m_data_out = '0; st = 0; cnt = 0; sg = 0; scyc = 0;
        forever begin
            @(posedge clk); #2;
            if (reset !== 1'b1) begin
                st = 0; m_busy = 1'b0; m_cs = 1'b1;
            end else if (st == 0) begin
                if (m_start === 1'b1) begin
                    cap_data = m_data_in; cap_cpol = m_cpol; cap_cpha = m_cpha;
                    cap_grant = grant; scyc = cyc;
                    for (int i = 0; i < N; i++) if (grant[i]) sg = i;
                    cnt = $urandom_range(0, 2);
                    st = hang ? 3 : 1;
                end
            end else if (st == 1) begin
                if (cnt == 0) begin m_busy = 1'b1; m_cs = 1'b0; cnt = $urandom_range(2, 9); st = 2; end
                else cnt--;
            end else if (st == 2) begin
                if (cnt == 0) begin m_busy = 1'b0; m_cs = 1'b1; m_data_out = sbytes[8*sg +: 8]; st = 0; end
                else cnt--;
            end else if (done !== '0) st = 0;
        end
    end

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return 0;
    endfunction

    task automatic observe;
        ob_done = '0; ob_err = 1'b0; ob_ss = '1; ob_cyc = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (m_cs === 1'b0) ob_ss = ss_n;
            if (done !== '0) begin ob_done = done; ob_err = err; ob_cyc = cyc; break; end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (grant !== '0) begin errors++; $display("FAIL rst_grant: got %b want 0", grant); end
        checks++; if (done !== '0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if ({err, m_start} !== 2'b00) begin errors++; $display("FAIL rst_err_start: got %b want 00", {err, m_start}); end
        checks++; if ({m_data_in, m_cpol, m_cpha} !== 10'd0) begin errors++; $display("FAIL rst_master: got %h want 0", {m_data_in, m_cpol, m_cpha}); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx: got %h want 00", rx_data); end
        checks++; if (ss_n !== '1) begin errors++; $display("FAIL rst_ss: got %b want 1111", ss_n); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({grant, m_start} !== '0) begin errors++; $display("FAIL idle_quiet: got %b want 0", {grant, m_start}); end
    endtask

    task automatic test_all_four(input logic [N-1:0] rq, input logic [8*N-1:0] tx, input logic [N-1:0] pol,
                                 input logic [N-1:0] pha, input logic [8*N-1:0] sb, input int extra);
        logic [N-1:0] pend, oh;
        int g, prev, left;
        tx_data = tx; cpol = pol; cpha = pha; sbytes = sb; left = extra; prev = -1;
        @(negedge clk);
        pend = rq; req = pend;
        while (pend != '0) begin
            g = pick(pend, ptr_m); oh = N'(1) << g;
            observe;
            checks++; if (ob_done !== oh) begin errors++; $display("FAIL rr_done: got %b want %b", ob_done, oh); end
            checks++; if (cap_grant !== oh) begin errors++; $display("FAIL rr_grant: got %b want %b", cap_grant, oh); end
            checks++; if ({cap_data, cap_cpol, cap_cpha} !== {tx[8*g +: 8], pol[g], pha[g]})
                begin errors++; $display("FAIL master_load: got %h/%b%b want %h/%b%b", cap_data, cap_cpol, cap_cpha, tx[8*g +: 8], pol[g], pha[g]); end
            checks++; if (rx_data !== sb[8*g +: 8]) begin errors++; $display("FAIL rr_rx: got %h want %h", rx_data, sb[8*g +: 8]); end
            checks++; if (ob_ss !== ~oh) begin errors++; $display("FAIL rr_ss: got %b want %b", ob_ss, ~oh); end
            checks++; if (ob_err !== 1'b0) begin errors++; $display("FAIL rr_err: got %b want 0", ob_err); end
            if (prev >= 0) begin
                checks++; if (scyc - prev !== 3) begin errors++; $display("FAIL b2b_gap: got %0d want 3", scyc - prev); end
            end
            pend[g] = 1'b0;
            if (left > 0) begin pend = pend | N'($urandom_range(0, (1 << N) - 1)); left--; end
            req = pend; ptr_m = (g + 1) % N; prev = (pend != '0) ? ob_cyc : -1;
            @(negedge clk);
            checks++; if (done !== '0) begin errors++; $display("FAIL done_width: got %b want 0", done); end
        end
        req = '0;
    endtask

    task automatic test_single;
        int rc, g;
        logic [N-1:0] oh;
        tx_data[7:0] = 8'hA5; cpol[0] = 1'b0; cpha[0] = 1'b0; sbytes[7:0] = 8'h3C;
        @(negedge clk);
        req = 4'b0001; rc = cyc;
        g = pick(req, ptr_m); oh = N'(1) << g;
        observe;
        req = '0;
        checks++; if (ob_done !== oh) begin errors++; $display("FAIL single_done: got %b want %b", ob_done, oh); end
        checks++; if (scyc - rc !== 2) begin errors++; $display("FAIL single_latency: got %0d want 2", scyc - rc); end
        checks++; if (cap_data !== 8'hA5) begin errors++; $display("FAIL single_slave_got: got %h want a5", cap_data); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL single_rx: got %h want 3c", rx_data); end
        checks++; if (ob_ss !== 4'b1110) begin errors++; $display("FAIL single_ss: got %b want 1110", ob_ss); end
        @(negedge clk);
        checks++; if (done !== '0) begin errors++; $display("FAIL single_done_width: got %b want 0", done); end
        ptr_m = (g + 1) % N;
    endtask

    task automatic test_round_robin;
        test_all_four(4'b0100, 32'($urandom), 4'($urandom), 4'($urandom), 32'($urandom) | 32'h01010101, 0);
        @(negedge clk);
        req = 4'b0101;
        observe;
        checks++; if (ob_done !== 4'b0001) begin errors++; $display("FAIL rr_first: got %b want 0001", ob_done); end
        req = 4'b0100;
        observe;
        checks++; if (ob_done !== 4'b0100) begin errors++; $display("FAIL rr_second: got %b want 0100", ob_done); end
        req = '0; ptr_m = 3;
    endtask

    task automatic test_reset_mid;
        int g;
        logic [N-1:0] oh;
        tx_data = 32'($urandom) | 32'h0000_0100; sbytes = 32'($urandom) | 32'h01010101;
        @(negedge clk);
        req = 4'b0010;
        for (int k = 0; k < 30 && m_busy !== 1'b1; k++) @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (grant !== '0) begin errors++; $display("FAIL arst_grant: got %b want 0", grant); end
        checks++; if (ss_n !== 4'hF) begin errors++; $display("FAIL arst_ss: got %b want 1111", ss_n); end
        checks++; if ({m_start, done} !== '0) begin errors++; $display("FAIL arst_start: got %b want 0", {m_start, done}); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL arst_rx: got %h want 00", rx_data); end
        checks++; if ({m_data_in, m_cpol, m_cpha} !== 10'd0) begin errors++; $display("FAIL arst_master: got %h want 0", {m_data_in, m_cpol, m_cpha}); end
        req = '0;
        @(negedge clk);
        reset = 1'b1; ptr_m = 0;
        repeat (3) @(negedge clk);
        checks++; if ({grant, m_start} !== '0) begin errors++; $display("FAIL arst_idle: got %b want 0", {grant, m_start}); end
        req = 4'b1111;
        g = pick(req, ptr_m); oh = N'(1) << g;
        observe;
        req = '0;
        checks++; if (ob_done !== oh) begin errors++; $display("FAIL arst_ptr: got %b want %b", ob_done, oh); end
        ptr_m = (g + 1) % N;
    endtask

    task automatic test_drop;
        int g;
        logic [N-1:0] oh;
        tx_data = 32'($urandom); sbytes = 32'($urandom) | 32'h01010101;
        @(negedge clk);
        req = 4'b0010;
        g = pick(req, ptr_m); oh = N'(1) << g;
        for (int k = 0; k < 30 && m_busy !== 1'b1; k++) @(negedge clk);
        req = '0;
        observe;
        checks++; if (ob_done !== oh) begin errors++; $display("FAIL drop_done: got %b want %b", ob_done, oh); end
        checks++; if (rx_data !== sbytes[8*g +: 8]) begin errors++; $display("FAIL drop_rx: got %h want %h", rx_data, sbytes[8*g +: 8]); end
        checks++; if (cap_data !== tx_data[8*g +: 8]) begin errors++; $display("FAIL drop_tx: got %h want %h", cap_data, tx_data[8*g +: 8]); end
        ptr_m = (g + 1) % N;
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int g;
        logic [N-1:0] oh, pend;
        logic [7:0] rx0;
        hang = 1'b1; rx0 = rx_data;
        @(negedge clk);
        pend = 4'b0011; req = pend;
        g = pick(pend, ptr_m); oh = N'(1) << g;
        observe;
        checks++; if (ob_done !== oh) begin errors++; $display("FAIL to_done: got %b want %b", ob_done, oh); end
        checks++; if (ob_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", ob_err); end
        checks++; if (ob_cyc - scyc !== TO) begin errors++; $display("FAIL to_delay: got %0d want %0d", ob_cyc - scyc, TO); end
        checks++; if (rx_data !== rx0) begin errors++; $display("FAIL to_rx: got %h want %h", rx_data, rx0); end
        hang = 1'b0; pend[g] = 1'b0; req = pend; ptr_m = (g + 1) % N;
        g = pick(pend, ptr_m); oh = N'(1) << g;
        observe;
        req = '0;
        checks++; if (ob_done !== oh) begin errors++; $display("FAIL to_next: got %b want %b", ob_done, oh); end
        checks++; if (ob_err !== 1'b0) begin errors++; $display("FAIL to_next_err: got %b want 0", ob_err); end
        ptr_m = (g + 1) % N;
    endtask
`endif

    task automatic test_random;
        for (int r = 0; r < 8; r++)
            test_all_four(N'($urandom_range(1, (1 << N) - 1)), 32'($urandom), N'($urandom), N'($urandom),
                          32'($urandom) | 32'h01010101, 4);
    endtask

    initial begin
        reset = 1'b0; req = '0; cpol = '0; cpha = '0; tx_data = '0; sbytes = '0;
        test_reset;
        test_all_four(4'b1111, 32'h44332211, 4'b1100, 4'b1010, 32'($urandom) | 32'h01010101, 0);
        test_single;
        test_round_robin;
        test_reset_mid;
        test_drop;
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout;
`endif
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares one spi_master instance between N requesters, each addressing its own slave.
- Selects requesters round-robin and latches the winner's byte and CPOL/CPHA mode.
- Pulses the master's start, tracks its busy, and returns the received byte.
- Decodes the master's single CS into one active-low slave select per requester.

Parameters:
N, 4, number of requesters and slave selects (2..8).
TIMEOUT_CYCLES, 64, clk cycles allowed for m_busy to rise after m_start (used only with SPI_ARB_TIMEOUT_EN).

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
req  input  N  per-requester transfer request; level, held until done
tx_data  input  8*N  byte for requester i in bits [8i+7:8i]
cpol  input  N  per-requester SPI clock polarity
cpha  input  N  per-requester SPI clock phase
grant  output  N  one-hot, high while requester i owns the master
done  output  N  one-cycle pulse to requester i when its transfer ends
err  output  1  one-cycle timeout pulse (macro only; otherwise tied 0)
rx_data  output  8  last received byte; valid from the done pulse until the next done
m_data_in  output  8  to spi_master data_in
m_cpol  output  1  to spi_master CPOL
m_cpha  output  1  to spi_master CPHA
m_start  output  1  to spi_master start; one-cycle pulse
m_busy  input  1  from spi_master busy
m_data_out  input  8  from spi_master data_out
m_cs  input  1  from spi_master CS
ss_n  output  N  per-slave select

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, priority pointer=0.
  - grant, done, err, m_start, m_data_in, m_cpol, m_cpha, rx_data all 0.
  - ss_n all 1.
  - An in-flight master transfer is abandoned; the master is reset by the same net.
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_END, DONE.
- IDLE: if req!=0, choose the first set bit scanning from the pointer upward, wrapping at N-1 to 0.
  - Registers the grant (one-hot).
  - Latches tx_data slice, cpol and cpha into m_data_in, m_cpol, m_cpha.
  - Goes to LOAD. Otherwise stays in IDLE.
- LOAD: one cycle so that mode and data are stable before start. Goes to START.
- START: m_start=1 for exactly this cycle. Goes to WAIT_BUSY.
- WAIT_BUSY: stays until m_busy=1, then goes to WAIT_END.
- WAIT_END: stays until m_busy=0. Then captures rx_data<=m_data_out and goes to DONE.
- DONE: for this single cycle:
  - done[g]=1;
  - grant cleared at the end of the cycle;
  - pointer<=(g+1) mod N.
  - Goes to IDLE.
- Latency: from req sampled in IDLE to m_start high is 2 cycles. Back-to-back grants are separated by exactly 1 IDLE cycle.
- ss_n[g]=m_cs (combinational) while grant[g]=1. Every other ss_n bit, and all bits in IDLE, are 1.
- Arbitration rules:
  - req changes after grant are ignored until DONE.
  - A req drop mid-transfer does not abort the transfer.
  - Simultaneous requests are served strictly in round-robin order; no requester waits more than N-1 transfers.
- m_data_in, m_cpol, m_cpha hold their latched values until the next LOAD.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears in START and increments each cycle in WAIT_BUSY.
  - If it reaches TIMEOUT_CYCLES with m_busy still 0:
    - err=1 and done[g]=1 for one cycle;
    - rx_data is unchanged;
    - grant is cleared and the pointer advances;
    - state goes to IDLE.
- Undefined: no counter; WAIT_BUSY waits indefinitely; err is constant 0.

Test Plan:
- Single requester: req=4'b0001, tx_data[7:0]=8'hA5, mode 0, slave returns 8'h3C.
  - m_start pulses 2 cycles after req; ss_n=4'b1110 while m_cs=0.
  - done[0] pulses once; rx_data=8'h3C; the slave captured A5.
- All four requesting, with distinct bytes 11/22/33/44 and modes 0..3.
  - Grants in order 0,1,2,3.
  - m_cpol/m_cpha match each requester's mode for its transfer.
  - Each done pulses once and each rx_data equals that slave's byte.
- Round-robin fairness: after requester 2 is served, req=4'b0101.
  - Next grant is 0, then 2.
- Reset asserted in WAIT_END:
  - Immediately grant=0, ss_n=4'hF, m_start=0, rx_data=0.
  - After release, state is IDLE and the pointer is 0.
- Requester 1 drops req mid-transfer:
  - The transfer completes and done[1] still pulses.
- With SPI_ARB_TIMEOUT_EN and a stub that holds m_busy=0, TIMEOUT_CYCLES=64:
  - err and done[g] pulse 64 cycles after m_start; rx_data is unchanged.
  - The next requester is then granted.
